// File: rtl/sar_frame_sequencer_pkg.sv
// Shared types and constants for the SAR frame sequencer.
package sar_pkg;

  localparam int SAR_W = 12;
  localparam logic [SAR_W-1:0] SAR_RESET_CODE = 12'h7FF;

  typedef enum logic [2:0] {
    IDLE,
    OUT,
    START,
    CONV,
    CAPTURE,
    WAIT
  } state_t;

endpackage

// File: rtl/sar_frame_sequencer_if.sv
// Signal bundle between the frame sequencer (master) and the DSP / SAR / DAC /
// comparator environment (slave).
interface sar_frame_sequencer_if;
  import sar_pkg::*;

  logic             enable;
  logic [SAR_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SAR_W-1:0] dac_data;
  logic             sh_n;
  logic             sar_s;
  logic             sar_d;
  logic [SAR_W-1:0] sar_q;
  logic             sar_cc;
  logic             cmp_in;
  logic [SAR_W-1:0] adc_data;
  logic             adc_valid;
  logic             underrun;
  logic             conv_err;

  modport master (
    input  enable, out_data, out_valid, sar_q, sar_cc, cmp_in,
    output out_ready, dac_data, sh_n, sar_s, sar_d,
           adc_data, adc_valid, underrun, conv_err
  );

  modport slave (
    output enable, out_data, out_valid, sar_q, sar_cc, cmp_in,
    input  out_ready, dac_data, sh_n, sar_s, sar_d,
           adc_data, adc_valid, underrun, conv_err
  );

endinterface

// File: rtl/sar_frame_sequencer_sample_hold_buf.sv
// One-entry valid/ready holding buffer for the next output sample; emptied by
// the frame-start pop strobe.
module sample_hold_buf
  import sar_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SAR_W-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic             pop,
  output logic             full,
  output logic [SAR_W-1:0] data
);

  logic             full_reg;
  logic [SAR_W-1:0] data_reg;

  // A push can only happen while empty and a pop only matters while full, so a
  // push coinciding with a frame-start pop is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (push_valid && !full_reg) begin
      full_reg <= 1'b1;
      data_reg <= push_data;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign push_ready = !full_reg;
  assign full       = full_reg;
  assign data       = data_reg;

endmodule

// File: rtl/sar_frame_sequencer.sv
// Frame sequencer: shows the output sample on the DAC, then lends the DAC to the
// SAR for one conversion per frame and captures the finished code.
module sar_frame_sequencer
  import sar_pkg::*;
#(
  parameter int FRAME_LEN    = 32,
  parameter int OUT_CYCLES   = 8,
  parameter int CONV_TIMEOUT = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  sar_frame_sequencer_if.master bus
);

  localparam int FC_W = $clog2(FRAME_LEN);
  localparam int CC_W = $clog2(CONV_TIMEOUT + 1);
  localparam logic [FC_W-1:0] FC_LAST    = FC_W'(FRAME_LEN - 1);
  localparam logic [FC_W-1:0] FC_OUT_END = FC_W'(OUT_CYCLES - 1);
  localparam logic [CC_W-1:0] CC_LAST    = CC_W'(CONV_TIMEOUT - 1);

  state_t           state_reg;
  logic [FC_W-1:0]  fc_reg;
  logic [CC_W-1:0]  conv_cnt_reg;
  logic [SAR_W-1:0] out_reg;
  logic [SAR_W-1:0] adc_reg;
  logic             adc_valid_reg;
  logic             underrun_reg;
  logic             conv_err_reg;

  logic             frame_load;
  logic             buf_full;
  logic [SAR_W-1:0] buf_data;
  logic             sar_phase;

  assign frame_load = bus.enable &&
                      ((state_reg == IDLE) || ((state_reg == WAIT) && (fc_reg == FC_LAST)));

  sample_hold_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_data  (bus.out_data),
    .push_valid (bus.out_valid),
    .push_ready (bus.out_ready),
    .pop        (frame_load),
    .full       (buf_full),
    .data       (buf_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      fc_reg        <= '0;
      conv_cnt_reg  <= '0;
      out_reg       <= '0;
      adc_reg       <= '0;
      adc_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
      conv_err_reg  <= 1'b0;
    end else begin
      adc_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
      conv_err_reg  <= 1'b0;
      fc_reg <= ((state_reg == IDLE) || (fc_reg == FC_LAST)) ? '0 : fc_reg + FC_W'(1);

      if (frame_load) begin
        state_reg <= OUT;
        if (buf_full) out_reg <= buf_data;
        else          underrun_reg <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: state_reg <= IDLE;
          OUT:  if (fc_reg == FC_OUT_END) state_reg <= START;
          START: begin
            state_reg    <= CONV;
            conv_cnt_reg <= '0;
          end
          // The code is taken on the way into CAPTURE so adc_valid lines up with it.
          CONV: begin
            if (!bus.sar_cc) begin
              state_reg     <= CAPTURE;
              adc_reg       <= bus.sar_q;
              adc_valid_reg <= 1'b1;
            end else if (conv_cnt_reg == CC_LAST) begin
              state_reg    <= WAIT;
              conv_err_reg <= 1'b1;
            end else begin
              conv_cnt_reg <= conv_cnt_reg + CC_W'(1);
            end
          end
          CAPTURE: state_reg <= WAIT;
          WAIT:    if (fc_reg == FC_LAST) state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // The SAR loop needs trial codes on the DAC in the same cycle they appear.
  assign sar_phase     = (state_reg == START) || (state_reg == CONV);
  assign bus.dac_data  = sar_phase ? bus.sar_q : out_reg;
  assign bus.sh_n      = !sar_phase;
  assign bus.sar_s     = (state_reg == CONV);
  assign bus.sar_d     = (state_reg == CONV) && bus.cmp_in;
  assign bus.adc_data  = adc_reg;
  assign bus.adc_valid = adc_valid_reg;
  assign bus.underrun  = underrun_reg;
  assign bus.conv_err  = conv_err_reg;

endmodule
